rr_mux_arbiter_8_v: RTL and testbench

Round-robin arbiter that shares one 8:1 mux datapath among 8 requesters. It drives the mux select code and one-hot grant. Grants are held for a bounded burst, then rotated. It sits in front of the 8:1 mux; its o_sel_code wires directly to the mux select input.

---
 rtl/rr_mux_arbiter_8_v.sv | 108 ++++++++++
 tb/tb_rr_mux_arbiter_8_v.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_8_v.sv
// Round-robin arbiter for an 8:1 mux: one-hot grant plus binary select, bounded hold bursts.
// Optional ARB_PRI0_EN: requester 0 wins every arbitration point it requests at.
module rr_mux_arbiter_8_v #(
   parameter int unsigned HOLD_MAX = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [7:0] i_req,
   output logic [7:0] o_grant,
   output logic [2:0] o_sel_code,
   output logic       o_valid,
   output logic       o_grant_last
);

   typedef enum logic {StIdle, StGrant} state_e;

   localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);

   state_e           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       sel_q, sel_d;
   logic [7:0]       grant_q, grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       start;
   logic       can_arb;
   logic       at_max;
   logic [2:0] win;

   // Walk from farthest to nearest so the lowest offset after ptr wins; ptr itself is last.
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
      logic [2:0] pick;
      logic [2:0] idx;
      pick = ptr;
      for (int k = 8; k >= 1; k--) begin
         idx = ptr + 3'(k);
         if (req[idx]) pick = idx;
      end
`ifdef ARB_PRI0_EN
      if (req[0]) pick = 3'd0;
`endif
      return pick;
   endfunction

   assign win     = rr_pick(i_req, ptr_q);
   assign can_arb = i_en && (i_req != 8'd0);
   assign at_max  = (cnt_q == HoldMax);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      start   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (can_arb) start = 1'b1;
         end
         StGrant: begin
            if (!i_req[sel_q] || at_max) begin
               if (can_arb) begin
                  start = 1'b1;
               end else begin
                  state_d = StIdle;
                  grant_d = 8'd0;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase

      if (start) begin
         state_d = StGrant;
         ptr_d   = win;
         sel_d   = win;
         grant_d = 8'd1 << win;
         cnt_d   = CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         ptr_q   <= 3'd7;
         sel_q   <= 3'd0;
         grant_q <= 8'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_grant      = grant_q;
   assign o_sel_code   = sel_q;
   assign o_valid      = (state_q == StGrant);
   assign o_grant_last = o_valid && at_max;

endmodule

// File: tb/tb_rr_mux_arbiter_8_v.sv
// Directed and randomized bench for rr_mux_arbiter_8_v against a cycle-level reference model.
module tb_rr_mux_arbiter_8_v;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [7:0] req = 8'd0;
   logic [7:0] o_grant;
   logic [2:0] o_sel_code;
   logic       o_valid;
   logic       o_grant_last;

   int checks = 0;
   int errors = 0;

   // Reference model: last owner, pointer, cycles into current grant, grant active.
   int m_own;
   int m_ptr;
   int m_cnt;
   bit m_act;

   rr_mux_arbiter_8_v #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_req       (req),
      .o_grant     (o_grant),
      .o_sel_code  (o_sel_code),
      .o_valid     (o_valid),
      .o_grant_last(o_grant_last)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_own = 0;
      m_ptr = 7;
      m_cnt = 0;
      m_act = 0;
   endtask

   task automatic model_arb();
      int pick;
      pick = -1;
      for (int k = 1; k <= 8; k++) begin
         if (pick < 0 && req[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
      end
`ifdef ARB_PRI0_EN
      if (req[0]) pick = 0;
`endif
      m_own = pick;
      m_ptr = pick;
      m_cnt = 1;
      m_act = 1;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (!m_act) begin
         if (en && req != 8'd0) model_arb();
      end else if (!req[m_own] || m_cnt == HOLD) begin
         if (en && req != 8'd0) model_arb();
         else m_act = 0;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic expect_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] eg;
      eg = m_act ? (8'd1 << m_own) : 8'd0;
      expect_val({tag, ".grant"}, o_grant, eg);
      expect_val({tag, ".sel"}, {5'd0, o_sel_code}, 8'(m_own));
      expect_val({tag, ".valid"}, {7'd0, o_valid}, {7'd0, m_act});
      expect_val({tag, ".last"}, {7'd0, o_grant_last}, {7'd0, (m_act && m_cnt == HOLD)});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Reset asserted between edges must clear outputs immediately.
   task automatic async_reset(input string tag);
      rst = 1'b1;
      #2;
      model_reset();
      check_all(tag);
      step(tag);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      step("por");
      step("por");
      expect_val("por.grant0", o_grant, 8'h00);
      rst = 1'b0;

      // Reset mid-grant of owner 3.
      en  = 1'b1;
      req = 8'h08;
      step("rst.g3");
      expect_val("rst.sel3", {5'd0, o_sel_code}, 8'd3);
      step("rst.g3b");
      rst = 1'b1;
      #2;
      model_reset();
      check_all("rst.async");
      expect_val("rst.async.grant", o_grant, 8'h00);
      req = 8'h01;
      step("rst.held");
      rst = 1'b0;
      step("rst.first");
      expect_val("rst.first.grant", o_grant, 8'h01);
      expect_val("rst.first.valid", {7'd0, o_valid}, 8'd1);

      // Full rotation, 4 cycles each, no gaps.
      req = 8'hFF;
      for (int i = 0; i < 36; i++) begin
         step("rot");
         expect_val("rot.nogap", {7'd0, o_valid}, 8'd1);
      end

      // Early release of owner 2 after 2 cycles.
      async_reset("early.rst");
      req = 8'h24;
      step("early.c1");
      expect_val("early.c1.grant", o_grant, 8'h04);
      step("early.c2");
      req = 8'h20;
      step("early.sw");
      expect_val("early.sw.grant", o_grant, 8'h20);
      expect_val("early.sw.sel", {5'd0, o_sel_code}, 8'd5);
      step("early.tail");

      // Lone requester 7 is regranted without a gap.
      async_reset("lone.rst");
      req = 8'h80;
      for (int i = 0; i < 12; i++) begin
         step("lone");
         expect_val("lone.sel", {5'd0, o_sel_code}, 8'd7);
         expect_val("lone.last", {7'd0, o_grant_last}, 8'((i % 4) == 3));
      end

      // Enable dropped in cycle 2 of owner 1.
      async_reset("en.rst");
      req = 8'h06;
      step("en.c1");
      step("en.c2");
      en = 1'b0;
      step("en.c3");
      step("en.c4");
      expect_val("en.c4.last", {7'd0, o_grant_last}, 8'd1);
      step("en.idle");
      expect_val("en.idle.valid", {7'd0, o_valid}, 8'd0);
      expect_val("en.idle.sel", {5'd0, o_sel_code}, 8'd1);
      step("en.idle2");
      en = 1'b1;
      step("en.re");
      expect_val("en.re.grant", o_grant, 8'h04);

      // Priority of requester 0 after owner 3 releases.
      async_reset("pri.rst");
      req = 8'h08;
      step("pri.g3");
      req = 8'h11;
      step("pri.next");
`ifdef ARB_PRI0_EN
      expect_val("pri.next.grant", o_grant, 8'h01);
`else
      expect_val("pri.next.grant", o_grant, 8'h10);
`endif

      // Randomized traffic with occasional async resets.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset("rnd.rst");
         end else begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) req = 8'd1 << $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) req = 8'd0;
            en = ($urandom_range(0, 7) != 0);
            step("rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
